// File: rtl/vga_timing_gen.sv
// VGA timing generator: raster counters, pixel request stage, blanked RGB/sync output stage.
// Two pixel slots of latency from counter to pins; pix_en=0 freezes every register.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   RGB_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             req_valid,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;

  logic             r_req_valid;
  logic [9:0]       r_req_x;
  logic [9:0]       r_req_y;
  logic             r_hs1;
  logic             r_vs1;
  logic             r_de1;
  logic             r_fs1;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [RGB_W-1:0] r_rgb;
  logic             r_fs;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_visible;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_fs;

  assign w_h_last  = (r_h_cnt == H_LAST);
  assign w_v_last  = (r_v_cnt == V_LAST);
  assign w_visible = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs_act  = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  // vsync spans whole lines, so it depends on the line counter only
  assign w_vs_act  = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_fs      = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= 10'd0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Request stage: coordinates go to the frame source one slot ahead of display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_x     <= 10'd0;
      r_req_y     <= 10'd0;
      r_hs1       <= 1'b0;
      r_vs1       <= 1'b0;
      r_de1       <= 1'b0;
      r_fs1       <= 1'b0;
    end else if (pix_en) begin
      r_req_valid <= w_visible;
      r_req_x     <= w_visible ? r_h_cnt : 10'd0;
      r_req_y     <= w_visible ? r_v_cnt : 10'd0;
      r_hs1       <= w_hs_act;
      r_vs1       <= w_vs_act;
      r_de1       <= w_visible;
      r_fs1       <= w_fs;
    end
  end

  // Display stage: rgb_in now carries the data for the stage-1 request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else if (pix_en) begin
      r_hsync <= r_hs1 ? HS_POL : ~HS_POL;
      r_vsync <= r_vs1 ? VS_POL : ~VS_POL;
      r_de    <= r_de1;
      r_rgb   <= r_de1 ? rgb_in : '0;
      r_fs    <= r_fs1;
    end
  end

  assign req_valid   = r_req_valid;
  assign req_x       = r_req_x;
  assign req_y       = r_req_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb_out     = r_rgb;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: two instances (default 640x480 timing and a tiny raster with positive hsync),
// checked every cycle against a slot-index model of the raster.
module tb_vga_timing_gen;

  typedef struct {
    int   ha, hf, hs, hb;
    int   va, vf, vs, vb;
    logic hp, vp;
  } cfg_t;

  localparam int N_CYC  = 14000;
  localparam int RST_AT = 7013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pe_a, pe_b;
  logic [11:0] rgb_a, rgb_b;

  logic        rv_a, hs_a, vs_a, de_a, fs_a;
  logic [9:0]  rx_a, ry_a;
  logic [11:0] ro_a;
  logic        rv_b, hs_b, vs_b, de_b, fs_b;
  logic [9:0]  rx_b, ry_b;
  logic [11:0] ro_b;

  int          n_cmp = 0;
  int          n_err = 0;

  cfg_t        cfg_a, cfg_b;
  int          ka, kb;
  logic [11:0] erg_a, erg_b;
  int          stall_cnt;

  always #10 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_a), .rgb_in(rgb_a),
    .req_valid(rv_a), .req_x(rx_a), .req_y(ry_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb_out(ro_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .RGB_W(12)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_b), .rgb_in(rgb_b),
    .req_valid(rv_b), .req_x(rx_b), .req_y(ry_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb_out(ro_b), .frame_start(fs_b)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Raster position of the s-th processed slot (s counts from 0 at reset release)
  function automatic void slot_pos(input cfg_t c, input int s, output int h, output int v);
    int ht, p;
    ht = c.ha + c.hf + c.hs + c.hb;
    p  = s % (ht * (c.va + c.vf + c.vs + c.vb));
    h  = p % ht;
    v  = p / ht;
  endfunction

  function automatic logic slot_vis(input cfg_t c, input int s);
    int h, v;
    if (s < 0) return 1'b0;
    slot_pos(c, s, h, v);
    return (h < c.ha) && (v < c.va);
  endfunction

  // k = number of pix_en edges since reset release; erg = model rgb_out
  task automatic check_dut(input string nm, input cfg_t c, input int k, input logic [11:0] erg,
                           input logic rv, input logic [9:0] rx, input logic [9:0] ry,
                           input logic hs, input logic vs, input logic de,
                           input logic [11:0] ro, input logic fs);
    int   h, v;
    logic vis, e_hs, e_vs, e_fs;
    vis = slot_vis(c, k - 1);
    h = 0; v = 0;
    if (k >= 1) slot_pos(c, k - 1, h, v);
    chk_eq({nm, ".req_valid"}, rv, vis);
    chk_eq({nm, ".req_x"}, rx, vis ? h : 0);
    chk_eq({nm, ".req_y"}, ry, vis ? v : 0);
    vis = slot_vis(c, k - 2);
    e_hs = ~c.hp; e_vs = ~c.vp; e_fs = 1'b0;
    if (k >= 2) begin
      slot_pos(c, k - 2, h, v);
      if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) e_hs = c.hp;
      if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) e_vs = c.vp;
      e_fs = (h == 0) && (v == 0);
    end
    chk_eq({nm, ".de"}, de, vis);
    chk_eq({nm, ".hsync"}, hs, e_hs);
    chk_eq({nm, ".vsync"}, vs, e_vs);
    chk_eq({nm, ".frame_start"}, fs, e_fs);
    chk_eq({nm, ".rgb_out"}, ro, erg);
  endtask

  task automatic check_all();
    check_dut("a", cfg_a, ka, erg_a, rv_a, rx_a, ry_a, hs_a, vs_a, de_a, ro_a, fs_a);
    check_dut("b", cfg_b, kb, erg_b, rv_b, rx_b, ry_b, hs_b, vs_b, de_b, ro_b, fs_b);
  endtask

  initial begin
    cfg_a = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b0, vp: 1'b0};
    cfg_b = '{ha: 16, hf: 4, hs: 6, hb: 5, va: 10, vf: 2, vs: 2, vb: 3, hp: 1'b1, vp: 1'b0};
    rst_n = 1'b0; pe_a = 1'b1; pe_b = 1'b1; rgb_a = 12'hABC; rgb_b = 12'h123;
    ka = 0; kb = 0; erg_a = '0; erg_b = '0; stall_cnt = 0;

    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      check_all();

      if (cyc == 3) begin
        chk_eq("first_rgb", ro_a, 12'hABC);
        chk_eq("first_de", de_a, 1'b1);
        chk_eq("first_fs", fs_a, 1'b1);
      end
      if (cyc == 5) chk_eq("fs_second_slot", fs_a, 1'b0);

      if (cyc == RST_AT) begin
        #3;
        rst_n = 1'b0;
        ka = 0; kb = 0; erg_a = '0; erg_b = '0;
        #1;
        check_all();
      end
      if (cyc == RST_AT + 2) rst_n = 1'b1;

      // pix_en pattern: alternating, tied high, random with 10-cycle stalls
      if (cyc < 200 || (cyc > RST_AT && cyc < RST_AT + 100)) begin
        pe_a = (cyc % 2) == 0;
        pe_b = pe_a;
      end else if (cyc < 4000 || cyc >= RST_AT + 100) begin
        pe_a = 1'b1;
        pe_b = 1'b1;
      end else begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          pe_a = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          stall_cnt = 9;
          pe_a = 1'b0;
        end else begin
          pe_a = $urandom_range(0, 3) != 0;
        end
        pe_b = $urandom_range(0, 1) != 0;
      end
      rgb_a = (cyc < 6) ? 12'hABC : 12'($urandom);
      rgb_b = 12'($urandom);

      if (rst_n) begin
        if (pe_a) begin
          erg_a = slot_vis(cfg_a, ka - 1) ? rgb_a : 12'h000;
          ka++;
        end
        if (pe_b) begin
          erg_b = slot_vis(cfg_b, kb - 1) ? rgb_b : 12'h000;
          kb++;
        end
      end

      @(negedge clk);
    end

    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
